mult_arbiter: RTL and testbench

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arb_pkg.sv | 19 +
 rtl/mult_arb_tagq.sv | 66 ++++++
 rtl/mult_arbiter.sv | 126 ++++++++++++
 tb/tb_mult_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
// Shared types and constants for the multiplier arbiter: FSM encoding,
// requester id type and operand/product widths.
package mult_arb_pkg;

  localparam int OP_W   = 8;
  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  typedef logic req_id_t;

  localparam req_id_t REQ_ID0 = 1'b0;
  localparam req_id_t REQ_ID1 = 1'b1;

endpackage

// File: rtl/mult_arb_tagq.sv
// In-flight tag queue: records which requester owns each outstanding multiply,
// popped in order as products complete.
module mult_arb_tagq
  import mult_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  req_id_t push_id,
  input  logic    pop,
  output logic    full,
  output logic    empty,
  output req_id_t head_id
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  req_id_t            mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic               push_s;
  logic               pop_s;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : ptr + PTR_W'(1);
  endfunction

  // A simultaneous pop lets a push through on a full queue: the head is read before the slot is overwritten.
  always_comb begin
    push_s  = push && (!full || pop);
    pop_s   = pop && !empty;
    full    = (count_r == CNT_W'(DEPTH));
    empty   = (count_r == CNT_W'(0));
    head_id = mem_r[rd_ptr_r];
  end

  // Pointer, count and storage update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= REQ_ID0;
      end
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= push_id;
        wr_ptr_r        <= next_ptr(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Two-requester arbiter in front of a pipelined multiplier FIFO with in-order result return.
// Define MULT_ARB_FIXED_PRIO_EN for fixed priority to requester 0 instead of round-robin.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int TAG_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [OP_W-1:0]   opa0,
  input  logic [OP_W-1:0]   opb0,
  input  logic [OP_W-1:0]   opa1,
  input  logic [OP_W-1:0]   opb1,
  output logic              gnt0,
  output logic              gnt1,
  input  logic [2:0]        left_sig,
  output logic              write_req,
  output logic [PROD_W-1:0] fifo_write_data,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] product,
  output logic              res_valid0,
  output logic              res_valid1,
  output logic [PROD_W-1:0] res_data,
  output logic              err_orphan
);

  state_t  state_r;
  req_id_t winner_s;
  logic    issue_s;
  logic    pop_s;
  logic    q_full_s;
  logic    q_empty_s;
  req_id_t head_id_s;
`ifndef MULT_ARB_FIXED_PRIO_EN
  req_id_t rr_prio_r;
`endif

  // Winner selection and issue/pop qualification.
  always_comb begin
`ifdef MULT_ARB_FIXED_PRIO_EN
    winner_s = req0 ? REQ_ID0 : REQ_ID1;
`else
    if (req0 && req1) begin
      winner_s = rr_prio_r;
    end else if (req0) begin
      winner_s = REQ_ID0;
    end else begin
      winner_s = REQ_ID1;
    end
`endif
    issue_s = (state_r == ST_IDLE) && (req0 || req1) && (left_sig >= 3'd1) && !q_full_s;
    pop_s   = prod_valid && !q_empty_s;
  end

  // Issue FSM; HOLD gives left_sig a cycle to reflect the write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= ST_IDLE;
      write_req       <= 1'b0;
      fifo_write_data <= {PROD_W{1'b0}};
      gnt0            <= 1'b0;
      gnt1            <= 1'b0;
`ifndef MULT_ARB_FIXED_PRIO_EN
      rr_prio_r       <= REQ_ID0;
`endif
    end else begin
      write_req <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (issue_s) begin
            state_r         <= ST_ISSUE;
            write_req       <= 1'b1;
            fifo_write_data <= (winner_s == REQ_ID1) ? {opa1, opb1} : {opa0, opb0};
            gnt0            <= (winner_s == REQ_ID0);
            gnt1            <= (winner_s == REQ_ID1);
`ifndef MULT_ARB_FIXED_PRIO_EN
            rr_prio_r       <= ~winner_s;
`endif
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: state_r <= ST_HOLD;
        ST_HOLD:  state_r <= ST_IDLE;
        default:  state_r <= ST_IDLE;
      endcase
    end
  end

  // Result return: steer the completed product to the owner at the queue head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid0 <= 1'b0;
      res_valid1 <= 1'b0;
      res_data   <= {PROD_W{1'b0}};
      err_orphan <= 1'b0;
    end else begin
      res_valid0 <= pop_s && (head_id_s == REQ_ID0);
      res_valid1 <= pop_s && (head_id_s == REQ_ID1);
      if (pop_s) begin
        res_data <= product;
      end
      if (prod_valid && q_empty_s) begin
        err_orphan <= 1'b1;
      end
    end
  end

  mult_arb_tagq #(
    .DEPTH(TAG_DEPTH)
  ) u_tagq (
    .clk    (clk),
    .rst    (rst),
    .push   (issue_s),
    .push_id(winner_s),
    .pop    (pop_s),
    .full   (q_full_s),
    .empty  (q_empty_s),
    .head_id(head_id_s)
  );

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: directed scenarios plus random traffic
// checked against a transaction-level model (id queue + issue cooldown).
module tb_mult_arbiter;

  localparam int TAG_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [7:0]  opa0, opb0, opa1, opb1;
  logic        gnt0, gnt1;
  logic [2:0]  left_sig;
  logic        write_req;
  logic [15:0] fifo_write_data;
  logic        prod_valid;
  logic [15:0] product;
  logic        res_valid0, res_valid1;
  logic [15:0] res_data;
  logic        err_orphan;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_q[$];
  int          m_cyc, m_ready;
  bit          m_rr;
  logic        m_wr, m_g0, m_g1, m_rv0, m_rv1, m_orph;
  logic [15:0] m_data, m_rd;

  always #5 clk = ~clk;

  mult_arbiter #(.TAG_DEPTH(TAG_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .opa0(opa0), .opb0(opb0), .opa1(opa1), .opb1(opb1),
    .gnt0(gnt0), .gnt1(gnt1),
    .left_sig(left_sig),
    .write_req(write_req), .fifo_write_data(fifo_write_data),
    .prod_valid(prod_valid), .product(product),
    .res_valid0(res_valid0), .res_valid1(res_valid1),
    .res_data(res_data), .err_orphan(err_orphan)
  );

  task automatic model_reset();
    m_q.delete();
    m_cyc = 0; m_ready = 0; m_rr = 1'b0;
    m_wr = 1'b0; m_g0 = 1'b0; m_g1 = 1'b0; m_rv0 = 1'b0; m_rv1 = 1'b0; m_orph = 1'b0;
    m_data = 16'h0000; m_rd = 16'h0000;
  endtask

  // Predict the next-edge outputs from the current inputs, then advance one clock.
  task automatic tick();
    int sz;
    bit id, w;
    sz = m_q.size();
    m_wr = 1'b0; m_g0 = 1'b0; m_g1 = 1'b0; m_rv0 = 1'b0; m_rv1 = 1'b0;
    if (prod_valid) begin
      if (sz > 0) begin
        id = m_q.pop_front();
        m_rd = product;
        if (id) m_rv1 = 1'b1; else m_rv0 = 1'b1;
      end else begin
        m_orph = 1'b1;
      end
    end
    if (m_cyc >= m_ready && (req0 || req1) && left_sig >= 3'd1 && sz < TAG_DEPTH) begin
`ifdef MULT_ARB_FIXED_PRIO_EN
      w = !req0;
`else
      w = (req0 && req1) ? m_rr : req1;
`endif
      m_q.push_back(w);
      m_wr = 1'b1; m_g0 = !w; m_g1 = w;
      m_data = w ? {opa1, opb1} : {opa0, opb0};
      m_rr = !w;
      m_ready = m_cyc + 3;
    end
    m_cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; prod_valid = 1'b0; left_sig = 3'd4;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; prod_valid = 1'b0; left_sig = 3'd0; product = 16'h0000;
    opa0 = 8'h00; opb0 = 8'h00; opa1 = 8'h00; opb1 = 8'h00;
    #12;
    checks++;
    if ({write_req, gnt0, gnt1, res_valid0, res_valid1, err_orphan, fifo_write_data, res_data} !== 38'd0) begin
      errors++;
      $display("FAIL reset_state: got %h expected 0", {write_req, gnt0, gnt1, res_valid0, res_valid1, err_orphan, fifo_write_data, res_data});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_single();
    do_reset();
    req0 = 1'b1; opa0 = 8'd45; opb0 = 8'd2; left_sig = 3'd4;
    tick();
    checks++;
    if ({write_req, gnt0, gnt1, fifo_write_data} !== {3'b110, 16'h2D02}) begin
      errors++;
      $display("FAIL single_issue: got wr=%b g0=%b g1=%b data=%h expected 1 1 0 2d02", write_req, gnt0, gnt1, fifo_write_data);
    end
    req0 = 1'b0;
    tick();
    checks++;
    if ({write_req, gnt0, fifo_write_data} !== {2'b00, 16'h2D02}) begin
      errors++;
      $display("FAIL single_hold: got wr=%b g0=%b data=%h expected 0 0 2d02", write_req, gnt0, fifo_write_data);
    end
    prod_valid = 1'b1; product = 16'h005A;
    tick();
    prod_valid = 1'b0;
    checks++;
    if ({res_valid0, res_valid1, res_data} !== {2'b10, 16'h005A}) begin
      errors++;
      $display("FAIL single_result: got rv0=%b rv1=%b data=%h expected 1 0 005a", res_valid0, res_valid1, res_data);
    end
    tick();
    checks++;
    if ({res_valid0, res_valid1, res_data} !== {2'b00, 16'h005A}) begin
      errors++;
      $display("FAIL single_result_pulse: got rv0=%b rv1=%b data=%h expected 0 0 005a", res_valid0, res_valid1, res_data);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    req0 = 1'b1; opa0 = 8'd23; opb0 = 8'd12;
    req1 = 1'b1; opa1 = 8'd15; opb1 = 8'hFA;
    tick();
    checks++;
    if ({write_req, gnt0, gnt1, fifo_write_data} !== {3'b110, 16'h170C}) begin
      errors++;
      $display("FAIL rr_first: got wr=%b g0=%b g1=%b data=%h expected 1 1 0 170c", write_req, gnt0, gnt1, fifo_write_data);
    end
    req0 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({write_req, gnt1} !== 2'b00) begin
        errors++;
        $display("FAIL rr_gap: cycle %0d got wr=%b g1=%b expected 0 0", i, write_req, gnt1);
      end
    end
    tick();
    checks++;
    if ({write_req, gnt0, gnt1, fifo_write_data} !== {3'b101, 16'h0FFA}) begin
      errors++;
      $display("FAIL rr_second: got wr=%b g0=%b g1=%b data=%h expected 1 0 1 0ffa", write_req, gnt0, gnt1, fifo_write_data);
    end
    req1 = 1'b0;
    prod_valid = 1'b1; product = 16'h0114;
    tick();
    checks++;
    if ({res_valid0, res_valid1, res_data} !== {2'b10, 16'h0114}) begin
      errors++;
      $display("FAIL rr_res0: got rv0=%b rv1=%b data=%h expected 1 0 0114", res_valid0, res_valid1, res_data);
    end
    product = 16'hFFA6;
    tick();
    prod_valid = 1'b0;
    checks++;
    if ({res_valid0, res_valid1, res_data} !== {2'b01, 16'hFFA6}) begin
      errors++;
      $display("FAIL rr_res1: got rv0=%b rv1=%b data=%h expected 0 1 ffa6", res_valid0, res_valid1, res_data);
    end
  endtask

  task automatic test_no_space();
    int bad;
    do_reset();
    left_sig = 3'd0; req1 = 1'b1; opa1 = 8'h5A; opb1 = 8'hC3;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({write_req, gnt1} !== 2'b00) begin
        errors++;
        $display("FAIL no_space_block: cycle %0d got wr=%b g1=%b expected 0 0", i, write_req, gnt1);
      end
    end
    left_sig = 3'd1;
    tick();
    checks++;
    if ({write_req, gnt1, fifo_write_data} !== {2'b11, 16'h5AC3}) begin
      errors++;
      $display("FAIL no_space_release: got wr=%b g1=%b data=%h expected 1 1 5ac3", write_req, gnt1, fifo_write_data);
    end
    req1 = 1'b0;
  endtask

  task automatic test_queue_full();
    int grants;
    do_reset();
    req0 = 1'b1; opa0 = 8'($urandom); opb0 = 8'($urandom); left_sig = 3'd4;
    grants = 0;
    for (int i = 0; i < 18; i++) begin
      tick();
      grants += int'(gnt0);
      checks++;
      if ({write_req, gnt0, gnt1, res_valid0, res_valid1, err_orphan} !== {m_wr, m_g0, m_g1, m_rv0, m_rv1, m_orph}) begin
        errors++;
        $display("FAIL full_flags: cycle %0d got %b expected %b", i, {write_req, gnt0, gnt1, res_valid0, res_valid1, err_orphan}, {m_wr, m_g0, m_g1, m_rv0, m_rv1, m_orph});
      end
    end
    checks++;
    if (grants != 4) begin
      errors++;
      $display("FAIL full_grant_count: got %0d expected 4", grants);
    end
    prod_valid = 1'b1; product = 16'($urandom);
    tick();
    prod_valid = 1'b0;
    checks++;
    if ({res_valid0, write_req, res_data} !== {2'b10, m_rd}) begin
      errors++;
      $display("FAIL full_pop: got rv0=%b wr=%b data=%h expected 1 0 %h", res_valid0, write_req, res_data, m_rd);
    end
    tick();
    checks++;
    if ({write_req, gnt0} !== 2'b11) begin
      errors++;
      $display("FAIL full_refill: got wr=%b g0=%b expected 1 1", write_req, gnt0);
    end
    req0 = 1'b0;
    // Exactly four results must drain before the queue reports an orphan.
    for (int i = 0; i < 5; i++) begin
      prod_valid = 1'b1; product = 16'($urandom);
      tick();
      checks++;
      if ({res_valid0, res_valid1, err_orphan} !== {(i < 4), 1'b0, (i == 4)}) begin
        errors++;
        $display("FAIL full_drain: pop %0d got rv0=%b rv1=%b orph=%b expected %b 0 %b", i, res_valid0, res_valid1, err_orphan, (i < 4), (i == 4));
      end
    end
    prod_valid = 1'b0;
  endtask

  task automatic test_orphan_and_reset();
    do_reset();
    prod_valid = 1'b1; product = 16'h1234;
    tick();
    prod_valid = 1'b0;
    checks++;
    if ({err_orphan, res_valid0, res_valid1} !== 3'b100) begin
      errors++;
      $display("FAIL orphan_set: got orph=%b rv0=%b rv1=%b expected 1 0 0", err_orphan, res_valid0, res_valid1);
    end
    repeat (3) tick();
    checks++;
    if (err_orphan !== 1'b1) begin
      errors++;
      $display("FAIL orphan_sticky: got %b expected 1", err_orphan);
    end
    do_reset();
    req0 = 1'b1; opa0 = 8'h11; opb0 = 8'h22;
    tick();
    checks++;
    if (write_req !== 1'b1) begin
      errors++;
      $display("FAIL mid_issue_setup: got wr=%b expected 1", write_req);
    end
    rst = 1'b1;
    req0 = 1'b0;
    #1;
    checks++;
    if ({write_req, gnt0, gnt1, res_valid0, res_valid1, err_orphan, fifo_write_data, res_data} !== 38'd0) begin
      errors++;
      $display("FAIL mid_issue_reset: got %h expected 0", {write_req, gnt0, gnt1, res_valid0, res_valid1, err_orphan, fifo_write_data, res_data});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    prod_valid = 1'b1; product = 16'h0042;
    tick();
    prod_valid = 1'b0;
    checks++;
    if ({err_orphan, res_valid0, res_valid1} !== 3'b100) begin
      errors++;
      $display("FAIL late_product_orphan: got orph=%b rv0=%b rv1=%b expected 1 0 0", err_orphan, res_valid0, res_valid1);
    end
  endtask

  task automatic test_back_to_back();
    int last;
    int g1_while_req0;
    do_reset();
    req0 = 1'b1; req1 = 1'b1; left_sig = 3'd4;
    opa0 = 8'h01; opb0 = 8'h02; opa1 = 8'h03; opb1 = 8'h04;
    last = -1;
    g1_while_req0 = 0;
    for (int i = 0; i < 30; i++) begin
      prod_valid = (m_q.size() > 0) && (i % 2 == 0);
      product = 16'($urandom);
      tick();
      if (gnt1) g1_while_req0++;
      checks++;
      if ({write_req, gnt0, gnt1, res_valid0, res_valid1, fifo_write_data, res_data} !== {m_wr, m_g0, m_g1, m_rv0, m_rv1, m_data, m_rd}) begin
        errors++;
        $display("FAIL b2b_model: cycle %0d got %h expected %h", i, {write_req, gnt0, gnt1, res_valid0, res_valid1, fifo_write_data, res_data}, {m_wr, m_g0, m_g1, m_rv0, m_rv1, m_data, m_rd});
      end
`ifndef MULT_ARB_FIXED_PRIO_EN
      if (gnt0 || gnt1) begin
        checks++;
        if (last == int'(gnt1)) begin
          errors++;
          $display("FAIL b2b_alternate: cycle %0d got grant to %0d twice expected alternation", i, int'(gnt1));
        end
        last = int'(gnt1);
      end
`endif
    end
`ifdef MULT_ARB_FIXED_PRIO_EN
    checks++;
    if (g1_while_req0 != 0) begin
      errors++;
      $display("FAIL fixed_prio: got %0d gnt1 pulses expected 0", g1_while_req0);
    end
`endif
    req0 = 1'b0; req1 = 1'b0; prod_valid = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (!req0 || m_g0) begin
        req0 = 1'($urandom_range(0, 1));
        opa0 = 8'($urandom); opb0 = 8'($urandom);
      end
      if (!req1 || m_g1) begin
        req1 = 1'($urandom_range(0, 1));
        opa1 = 8'($urandom); opb1 = 8'($urandom);
      end
      left_sig = 3'($urandom_range(0, 4));
      prod_valid = ($urandom_range(0, 3) == 0);
      product = 16'($urandom);
      tick();
      checks++;
      if ({write_req, gnt0, gnt1, res_valid0, res_valid1, err_orphan, fifo_write_data, res_data} !==
          {m_wr, m_g0, m_g1, m_rv0, m_rv1, m_orph, m_data, m_rd}) begin
        errors++;
        $display("FAIL random_model: cycle %0d got %h expected %h", i,
                 {write_req, gnt0, gnt1, res_valid0, res_valid1, err_orphan, fifo_write_data, res_data},
                 {m_wr, m_g0, m_g1, m_rv0, m_rv1, m_orph, m_data, m_rd});
      end
    end
    req0 = 1'b0; req1 = 1'b0; prod_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_no_space();
    test_queue_full();
    test_orphan_and_reset();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
